// File: rtl/zmod_txlink.sv
// Transmit link framer: trains the far-end receiver, then splits 32-bit stream words
// into MSB-first bytes with a first-byte frame marker for an external 8:1 OSERDES.
module zmod_txlink #(
    parameter int          TRAIN_CYCLES  = 256,
    parameter logic [7:0]  TRAIN_PATTERN = 8'hF0,
    parameter logic [7:0]  IDLE_BYTE     = 8'h00
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        locked,
    input  logic        train_req,
    input  logic [31:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [7:0]  txd,
    output logic        txframe,
    output logic        trained,
    output logic [31:0] word_count,
    output logic [1:0]  state_dbg
);

    localparam int CW = (TRAIN_CYCLES > 1) ? $clog2(TRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(TRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        TRAIN     = 2'd1,
        IDLE      = 2'd2,
        SEND      = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           pending_q, pending_d;
    logic [31:0]    word_q, word_d;
    logic [7:0]     txd_q, txd_d;
    logic           txframe_q, txframe_d;
    logic           trained_q, trained_d;
    logic [31:0]    word_count_q, word_count_d;
    logic           accept;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    // Handshake: a word transfers on any rising edge where s_tvalid && s_tready.
    // Ready is offered in IDLE, or on the last byte of a word when no retrain is queued,
    // so back-to-back words leave no gap; a train_req always suppresses the handshake.
    assign s_tready = locked && !train_req &&
                      ((state_q == IDLE) ||
                       ((state_q == SEND) && (idx_q == 2'd3) && !pending_q));
    assign accept   = s_tvalid && s_tready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        word_d       = word_q;
        txd_d        = txd_q;
        txframe_d    = txframe_q;
        trained_d    = trained_q;
        word_count_d = word_count_q;

        if (!locked) begin
            // Losing lock abandons any word in flight without counting it.
            state_d   = WAIT_LOCK;
            txd_d     = IDLE_BYTE;
            txframe_d = 1'b0;
            trained_d = 1'b0;
            pending_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    state_d   = TRAIN;
                    cnt_d     = CNT_LOAD;
                    txd_d     = TRAIN_PATTERN;
                    txframe_d = 1'b0;
                    trained_d = 1'b0;
                end
                TRAIN: begin
                    txframe_d = 1'b0;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                        txd_d = TRAIN_PATTERN;
                    end else begin
                        state_d   = IDLE;
                        txd_d     = IDLE_BYTE;
                        trained_d = 1'b1;
                    end
                end
                IDLE: begin
                    txframe_d = 1'b0;
                    txd_d     = IDLE_BYTE;
                    if (train_req) begin
                        state_d   = TRAIN;
                        cnt_d     = CNT_LOAD;
                        txd_d     = TRAIN_PATTERN;
                        trained_d = 1'b0;
                    end else if (accept) begin
                        state_d   = SEND;
                        idx_d     = 2'd0;
                        word_d    = s_tdata;
                        txd_d     = s_tdata[31:24];
                        txframe_d = 1'b1;
                    end
                end
                SEND: begin
                    txframe_d = 1'b0;
                    if (idx_q != 2'd3) begin
                        idx_d     = idx_q + 2'd1;
                        txd_d     = byte_sel(word_q, idx_q + 2'd1);
                        pending_d = pending_q | train_req;
                    end else begin
                        word_count_d = word_count_q + 32'd1;
                        if (pending_q || train_req) begin
                            state_d   = TRAIN;
                            cnt_d     = CNT_LOAD;
                            txd_d     = TRAIN_PATTERN;
                            trained_d = 1'b0;
                            pending_d = 1'b0;
                        end else if (accept) begin
                            idx_d     = 2'd0;
                            word_d    = s_tdata;
                            txd_d     = s_tdata[31:24];
                            txframe_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                            txd_d   = IDLE_BYTE;
                        end
                    end
                end
                default: begin
                    state_d = WAIT_LOCK;
                    txd_d   = IDLE_BYTE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= WAIT_LOCK;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            word_q       <= 32'd0;
            txd_q        <= IDLE_BYTE;
            txframe_q    <= 1'b0;
            trained_q    <= 1'b0;
            word_count_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            word_q       <= word_d;
            txd_q        <= txd_d;
            txframe_q    <= txframe_d;
            trained_q    <= trained_d;
            word_count_q <= word_count_d;
        end
    end

    assign txd        = txd_q;
    assign txframe    = txframe_q;
    assign trained    = trained_q;
    assign word_count = word_count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_zmod_txlink.sv
// Bench for zmod_txlink: directed vector table, multi-cycle corner sequences and a
// randomized run checked against a queue-based model of the byte stream.
module tb_zmod_txlink;

    localparam int         T    = 8;
    localparam logic [7:0] PAT  = 8'hF0;
    localparam logic [7:0] IDLB = 8'h00;

    logic        clk = 1'b0;
    logic        rstn, locked, train_req, s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tready, txframe, trained;
    logic [7:0]  txd;
    logic [31:0] word_count;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    zmod_txlink #(.TRAIN_CYCLES(T), .TRAIN_PATTERN(PAT), .IDLE_BYTE(IDLB)) dut (
        .clk(clk), .rstn(rstn), .locked(locked), .train_req(train_req),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .txd(txd), .txframe(txframe), .trained(trained),
        .word_count(word_count), .state_dbg(state_dbg)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the link is a queue of bytes still to be shown; a word pushes four bytes,
    // a training sequence pushes T pattern bytes; one byte is shown per cycle.
    typedef struct packed {
        logic [7:0] b;
        logic       fr;
        logic       last;
        logic       is_train;
    } ent_t;

    ent_t        m_q[$];
    ent_t        m_cur;
    bit          m_up, m_trained, m_pending, m_known;
    logic [31:0] m_count;

    function automatic ent_t mk(input logic [7:0] b, input logic fr, input logic last, input logic tr);
        ent_t e;
        e.b = b; e.fr = fr; e.last = last; e.is_train = tr;
        return e;
    endfunction

    function automatic bit model_ready(input logic l, input logic tr);
        return l && !tr && m_up && m_trained && (m_q.size() == 0) && !m_pending;
    endfunction

    task automatic model_fill_train();
        for (int i = 0; i < T; i++) m_q.push_back(mk(PAT, 1'b0, 1'b0, 1'b1));
        m_trained = 1'b0;
    endtask

    task automatic model_edge(input logic r, input logic l, input logic tr, input logic tv,
                              input logic [31:0] td);
        bit rdy;
        rdy = model_ready(l, tr);
        if (!r || !l) begin
            m_up = 0; m_q.delete(); m_trained = 0; m_pending = 0;
            m_cur = mk(IDLB, 1'b0, 1'b0, 1'b0);
            if (!r) begin
                m_count = 32'd0;
                m_known = 1;
            end
        end else if (!m_up) begin
            m_up = 1;
            model_fill_train();
            m_cur = m_q.pop_front();
        end else begin
            if (m_cur.last) m_count = m_count + 32'd1;
            if (m_trained && m_q.size() != 0 && tr) m_pending = 1;
            if (m_trained && m_q.size() == 0 && (m_pending || tr)) begin
                model_fill_train();
                m_pending = 0;
            end else if (tv && rdy) begin
                m_q.push_back(mk(td[31:24], 1'b1, 1'b0, 1'b0));
                m_q.push_back(mk(td[23:16], 1'b0, 1'b0, 1'b0));
                m_q.push_back(mk(td[15:8],  1'b0, 1'b0, 1'b0));
                m_q.push_back(mk(td[7:0],   1'b0, 1'b1, 1'b0));
            end
            if (m_q.size() != 0) begin
                m_cur = m_q.pop_front();
            end else begin
                if (m_cur.is_train) m_trained = 1;
                m_cur = mk(IDLB, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    logic cur_r, cur_l, cur_tr, cur_tv;
    logic [31:0] cur_td;

    task automatic drive(input logic r, input logic l, input logic tr, input logic tv,
                         input logic [31:0] td);
        rstn = r; locked = l; train_req = tr; s_tvalid = tv; s_tdata = td;
        cur_r = r; cur_l = l; cur_tr = tr; cur_tv = tv; cur_td = td;
        #1;
        if (m_known && r) check("m_ready", s_tready, model_ready(l, tr));
    endtask

    task automatic edge_and_check();
        @(posedge clk);
        model_edge(cur_r, cur_l, cur_tr, cur_tv, cur_td);
        @(negedge clk);
        if (m_known) begin
            check("m_txd", txd, m_cur.b);
            check("m_txframe", txframe, m_cur.fr);
            check("m_trained", trained, m_trained);
            check("m_word_count", word_count, m_count);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic tr, input logic tv,
                        input logic [31:0] td);
        drive(r, l, tr, tv, td);
        edge_and_check();
    endtask

    // First pattern byte is already on txd; counts the run and checks it ends trained.
    task automatic expect_training(input string name);
        int n;
        bit done;
        n = (txd == PAT) ? 1 : 0;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            step(1, 1, 0, 0, 32'd0);
            if (txd == PAT) n++;
            else done = 1;
        end
        check({name, "_pattern_len"}, n, T);
        check({name, "_trained"}, trained, 1'b1);
        check({name, "_idle_byte"}, txd, IDLB);
    endtask

    typedef struct {
        logic        r, l, tr, tv;
        logic [31:0] td;
        logic [7:0]  e_txd;
        logic        e_fr, e_trained, e_ready;
        logic [31:0] e_count;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic l, input logic tr, input logic tv,
                                input logic [31:0] td, input logic [7:0] e_txd, input logic e_fr,
                                input logic e_trained, input logic e_ready, input logic [31:0] e_count);
        vec_t v;
        v.r = r; v.l = l; v.tr = tr; v.tv = tv; v.td = td;
        v.e_txd = e_txd; v.e_fr = e_fr; v.e_trained = e_trained;
        v.e_ready = e_ready; v.e_count = e_count;
        tbl.push_back(v);
    endfunction

    initial begin
        m_q.delete();
        m_cur = mk(IDLB, 1'b0, 1'b0, 1'b0);
        m_up = 0; m_trained = 0; m_pending = 0; m_known = 0; m_count = 32'd0;

        // Reset, training, single word, back-to-back words.
        for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 32'd0, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < T; i++) add(1, 1, 0, 0, 32'd0, 8'hF0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 32'd0,        8'h00, 0, 1, 0, 0);
        add(1, 1, 0, 1, 32'hDEADBEEF, 8'hDE, 1, 1, 1, 0);
        add(1, 1, 0, 0, 32'd0,        8'hAD, 0, 1, 0, 0);
        add(1, 1, 0, 0, 32'd0,        8'hBE, 0, 1, 0, 0);
        add(1, 1, 0, 0, 32'd0,        8'hEF, 0, 1, 0, 0);
        add(1, 1, 0, 0, 32'd0,        8'h00, 0, 1, 1, 1);
        add(1, 1, 0, 1, 32'h01020304, 8'h01, 1, 1, 1, 1);
        add(1, 1, 0, 1, 32'h05060708, 8'h02, 0, 1, 0, 1);
        add(1, 1, 0, 1, 32'h05060708, 8'h03, 0, 1, 0, 1);
        add(1, 1, 0, 1, 32'h05060708, 8'h04, 0, 1, 0, 1);
        add(1, 1, 0, 1, 32'h05060708, 8'h05, 1, 1, 1, 2);
        add(1, 1, 0, 0, 32'd0,        8'h06, 0, 1, 0, 2);
        add(1, 1, 0, 0, 32'd0,        8'h07, 0, 1, 0, 2);
        add(1, 1, 0, 0, 32'd0,        8'h08, 0, 1, 0, 2);
        add(1, 1, 0, 0, 32'd0,        8'h00, 0, 1, 1, 3);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].l, tbl[i].tr, tbl[i].tv, tbl[i].td);
            if (tbl[i].r) check($sformatf("tbl%0d_ready", i), s_tready, tbl[i].e_ready);
            edge_and_check();
            check($sformatf("tbl%0d_txd", i), txd, tbl[i].e_txd);
            check($sformatf("tbl%0d_txframe", i), txframe, tbl[i].e_fr);
            check($sformatf("tbl%0d_trained", i), trained, tbl[i].e_trained);
            check($sformatf("tbl%0d_count", i), word_count, tbl[i].e_count);
        end

        // Retrain requested while byte 1 is on the wire: word finishes, then training.
        step(1, 1, 0, 1, 32'hAABBCCDD);
        check("rt_byte0", txd, 8'hAA);
        step(1, 1, 0, 0, 32'd0);
        check("rt_byte1", txd, 8'hBB);
        step(1, 1, 1, 0, 32'd0);
        check("rt_byte2", txd, 8'hCC);
        step(1, 1, 0, 0, 32'd0);
        check("rt_byte3", txd, 8'hDD);
        drive(1, 1, 0, 1, 32'h12345678);
        check("rt_ready_idx3", s_tready, 1'b0);
        edge_and_check();
        check("rt_pattern", txd, PAT);
        check("rt_trained_low", trained, 1'b0);
        check("rt_count", word_count, 32'd4);
        expect_training("rt");

        // Lock loss while byte 2 is on the wire.
        step(1, 1, 0, 1, 32'h11223344);
        step(1, 1, 0, 0, 32'd0);
        step(1, 1, 0, 0, 32'd0);
        check("ll_byte2", txd, 8'h33);
        step(1, 0, 0, 0, 32'd0);
        check("ll_txd", txd, IDLB);
        check("ll_trained", trained, 1'b0);
        check("ll_count", word_count, 32'd4);
        check("ll_frame", txframe, 1'b0);
        step(1, 1, 0, 0, 32'd0);
        check("ll_pattern", txd, PAT);
        expect_training("ll");

        // Counter wrap.
        force dut.word_count_q = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        step(1, 1, 0, 0, 32'd0);
        release dut.word_count_q;
        step(1, 1, 0, 0, 32'd0);
        check("wrap_pre", word_count, 32'hFFFF_FFFF);
        step(1, 1, 0, 1, 32'h0A0B0C0D);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 32'd0);
        check("wrap_count", word_count, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 999) != 0),
                 ($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 29) == 0),
                 logic'($urandom_range(0, 1)),
                 $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
